// File: rtl/mcoc_dump_def.sv
// Shared constants for the hex-dump transmitter: ASCII characters and FSM encodings.
package mcoc_dump_def;

  localparam logic [7:0] CHR_LF  = 8'h0a;
  localparam logic [7:0] CHR_SPC = 8'h20;
  localparam logic [7:0] CHR_ATM = 8'h40;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_CAP  = 3'd3;
  localparam logic [2:0] ST_WHEX = 3'd4;
  localparam logic [2:0] ST_SEP  = 3'd5;
  localparam logic [2:0] ST_FIN  = 3'd6;

endpackage

// File: rtl/mcoc_hex_nib.sv
// Nibble to lowercase ASCII hex digit.
module mcoc_hex_nib (
  input  logic [3:0] i_nib,
  output logic [7:0] o_chr_c
);

  assign o_chr_c = (i_nib < 4'd10) ? (8'h30 + 8'(i_nib)) : (8'h57 + 8'(i_nib));

endmodule

// File: rtl/mcoc_rom_dump.sv
// Memory range hex-dump transmitter: emits "@addr\n" then hex words in loader text format.
module mcoc_rom_dump
  import mcoc_dump_def::*;
#(
  parameter int unsigned AW  = 12,
  parameter int unsigned WPL = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_adr,
  input  logic [AW:0]   word_cnt,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_adr,
  output logic          mem_re,
  input  logic [15:0]   mem_dat,
  output logic [7:0]    tx_dat,
  output logic          tx_vld,
  input  logic          tx_rdy
);

  localparam int unsigned LW = 8;
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [2:0]    r_state, w_state_nxt;
  logic [AW-1:0] r_adr, w_adr_nxt;
  logic [AW:0]   r_rem, w_rem_nxt;
  logic [LW-1:0] r_line, w_line_nxt;
  logic [15:0]   r_hold, w_hold_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic          r_tx_vld, w_tx_vld_nxt;
  logic [7:0]    r_tx_dat, w_tx_dat_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_mem_re, w_mem_re_nxt;
  logic [AW-1:0] r_mem_adr, w_mem_adr_nxt;

  logic [15:0]   w_src;
  logic [1:0]    w_dig;
  logic [3:0]    w_nib;
  logic [7:0]    w_chr;
  logic          w_xfer;
  logic          w_sep_lf;
  logic [AW-1:0] w_adr_inc;

  assign w_xfer    = r_tx_vld && tx_rdy;
  assign w_sep_lf  = (r_line == LW'(WPL - 1)) || (r_rem == CNT_ONE);
  assign w_adr_inc = r_adr + AW'(1);

  // Digit source: address in the header, incoming read data while capturing, hold register otherwise.
  always_comb begin
    w_src = r_hold;
    w_dig = 2'd0;
    case (r_state)
      ST_HDR: begin
        w_src = 16'(r_adr);
        w_dig = r_idx[1:0];
      end
      ST_CAP:  w_src = mem_dat;
      ST_WHEX: w_dig = r_idx[1:0] + 2'd1;
      default: ;
    endcase
    case (w_dig)
      2'd0:    w_nib = w_src[15:12];
      2'd1:    w_nib = w_src[11:8];
      2'd2:    w_nib = w_src[7:4];
      default: w_nib = w_src[3:0];
    endcase
  end

  mcoc_hex_nib u_hex_nib (
    .i_nib   (w_nib),
    .o_chr_c (w_chr)
  );

  // Next-state and next-output logic; tx_dat is reloaded only on transfer so it holds under back-pressure.
  always_comb begin
    w_state_nxt   = r_state;
    w_adr_nxt     = r_adr;
    w_rem_nxt     = r_rem;
    w_line_nxt    = r_line;
    w_hold_nxt    = r_hold;
    w_idx_nxt     = r_idx;
    w_tx_vld_nxt  = r_tx_vld;
    w_tx_dat_nxt  = r_tx_dat;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_mem_re_nxt  = 1'b0;
    w_mem_adr_nxt = r_mem_adr;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (word_cnt == '0) begin
            w_state_nxt = ST_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt  = ST_HDR;
            w_adr_nxt    = start_adr;
            w_rem_nxt    = word_cnt;
            w_line_nxt   = '0;
            w_idx_nxt    = 3'd0;
            w_busy_nxt   = 1'b1;
            w_tx_vld_nxt = 1'b1;
            w_tx_dat_nxt = CHR_ATM;
          end
        end
      end
      ST_HDR: begin
        if (w_xfer) begin
          if (r_idx == 3'd5) begin
            w_tx_vld_nxt  = 1'b0;
            w_state_nxt   = ST_RD;
            w_mem_re_nxt  = 1'b1;
            w_mem_adr_nxt = r_adr;
          end else begin
            w_idx_nxt    = r_idx + 3'd1;
            w_tx_dat_nxt = (r_idx == 3'd4) ? CHR_LF : w_chr;
          end
        end
      end
      ST_RD: w_state_nxt = ST_CAP;
      ST_CAP: begin
        w_hold_nxt   = mem_dat;
        w_idx_nxt    = 3'd0;
        w_tx_vld_nxt = 1'b1;
        w_tx_dat_nxt = w_chr;
        w_state_nxt  = ST_WHEX;
      end
      ST_WHEX: begin
        if (w_xfer) begin
          if (r_idx == 3'd3) begin
            w_tx_dat_nxt = w_sep_lf ? CHR_LF : CHR_SPC;
            w_state_nxt  = ST_SEP;
          end else begin
            w_idx_nxt    = r_idx + 3'd1;
            w_tx_dat_nxt = w_chr;
          end
        end
      end
      ST_SEP: begin
        if (w_xfer) begin
          w_tx_vld_nxt = 1'b0;
          w_adr_nxt    = w_adr_inc;
          w_rem_nxt    = r_rem - CNT_ONE;
          w_line_nxt   = w_sep_lf ? '0 : (r_line + LW'(1));
          if (r_rem == CNT_ONE) begin
            w_state_nxt = ST_FIN;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt   = ST_RD;
            w_mem_re_nxt  = 1'b1;
            w_mem_adr_nxt = w_adr_inc;
          end
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE) && (r_state != ST_FIN)) begin
      w_state_nxt  = ST_FIN;
      w_tx_vld_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b1;
      w_mem_re_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_adr     <= '0;
      r_rem     <= '0;
      r_line    <= '0;
      r_hold    <= '0;
      r_idx     <= '0;
      r_tx_vld  <= 1'b0;
      r_tx_dat  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mem_re  <= 1'b0;
      r_mem_adr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_adr     <= w_adr_nxt;
      r_rem     <= w_rem_nxt;
      r_line    <= w_line_nxt;
      r_hold    <= w_hold_nxt;
      r_idx     <= w_idx_nxt;
      r_tx_vld  <= w_tx_vld_nxt;
      r_tx_dat  <= w_tx_dat_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_mem_re  <= w_mem_re_nxt;
      r_mem_adr <= w_mem_adr_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign mem_adr = r_mem_adr;
  assign mem_re  = r_mem_re;
  assign tx_dat  = r_tx_dat;
  assign tx_vld  = r_tx_vld;

endmodule

// File: tb/tb_mcoc_rom_dump.sv
// Scoreboard bench for mcoc_rom_dump: model-built byte queues compared against captured transfers.
module tb_mcoc_rom_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [11:0] start_adr = '0;
  logic [12:0] word_cnt = '0;
  logic        abort = 1'b0;
  logic        tx_rdy = 1'b1;

  logic        busy1, done1, mem_re1, tx_vld1;
  logic        busy2, done2, mem_re2, tx_vld2;
  logic [11:0] mem_adr1, mem_adr2;
  logic [15:0] mem_dat1, mem_dat2;
  logic [7:0]  tx_dat1, tx_dat2;

  logic [15:0] mem [4096];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [11:0] adr_q[$];
  int done_cnt, stall_err, busy_after;
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_dat1 <= mem[mem_adr1];
    mem_dat2 <= mem[mem_adr2];
  end

  mcoc_rom_dump #(.AW(12), .WPL(8)) dut (
    .clk(clk), .rst(rst), .start(start1), .start_adr(start_adr), .word_cnt(word_cnt),
    .abort(abort), .busy(busy1), .done(done1), .mem_adr(mem_adr1), .mem_re(mem_re1),
    .mem_dat(mem_dat1), .tx_dat(tx_dat1), .tx_vld(tx_vld1), .tx_rdy(tx_rdy)
  );

  mcoc_rom_dump #(.AW(12), .WPL(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .start_adr(start_adr), .word_cnt(word_cnt),
    .abort(abort), .busy(busy2), .done(done2), .mem_adr(mem_adr2), .mem_re(mem_re2),
    .mem_dat(mem_dat2), .tx_dat(tx_dat2), .tx_vld(tx_vld2), .tx_rdy(tx_rdy)
  );

  // Reference byte stream for a dump of cnt words from adr with wpl words per line.
  function automatic void push_exp(input logic [11:0] adr, input int cnt, input int wpl);
    string hx = "0123456789abcdef";
    logic [15:0] a16, w;
    a16 = {4'h0, adr};
    exp_q.push_back(8'h40);
    for (int k = 3; k >= 0; k--) exp_q.push_back(hx[int'((a16 >> (4 * k)) & 16'hf)]);
    exp_q.push_back(8'h0a);
    for (int i = 0; i < cnt; i++) begin
      w = mem[12'(int'(adr) + i)];
      for (int k = 3; k >= 0; k--) exp_q.push_back(hx[int'((w >> (4 * k)) & 16'hf)]);
      exp_q.push_back(((i % wpl) == wpl - 1 || i == cnt - 1) ? 8'h0a : 8'h20);
    end
  endfunction

  // Drives tx_rdy / optional spurious start and records transfers, reads and done pulses.
  task automatic run(input bit sel, input int rdy_pct, input int spur_cyc, input int max_cyc);
    bit seen, pv_stall, v, r, dn, b, re;
    logic [7:0] d, pv_dat;
    logic [11:0] ma;
    int post;
    got_q.delete(); adr_q.delete();
    done_cnt = 0; stall_err = 0; busy_after = 0;
    seen = 0; pv_stall = 0; pv_dat = '0; post = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0;
      tx_rdy = ($urandom_range(99) < rdy_pct);
      if (c == spur_cyc) begin
        start1 = 1'b1; start_adr = 12'h123; word_cnt = 13'd7;
      end
      @(negedge clk);
      v  = sel ? tx_vld2 : tx_vld1;
      r  = tx_rdy;
      d  = sel ? tx_dat2 : tx_dat1;
      dn = sel ? done2 : done1;
      b  = sel ? busy2 : busy1;
      re = sel ? mem_re2 : mem_re1;
      ma = sel ? mem_adr2 : mem_adr1;
      if (pv_stall && (!v || d !== pv_dat)) stall_err++;
      pv_stall = v && !r;
      pv_dat = d;
      if (v && r) got_q.push_back(d);
      if (re) adr_q.push_back(ma);
      if (dn) done_cnt++;
      if (seen) begin
        post++;
        if (b) busy_after++;
        if (post == 3) break;
      end
      if (dn) begin
        seen = 1;
        if (b) busy_after++;
      end
    end
    tx_rdy = 1'b1;
  endtask

  task automatic test_reset();
    n_run++;
    if ({busy1, done1, mem_re1, tx_vld1, mem_adr1, tx_dat1} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got b=%0b d=%0b re=%0b v=%0b adr=%03h dat=%02h, all required 0",
               busy1, done1, mem_re1, tx_vld1, mem_adr1, tx_dat1);
    end
  endtask

  task automatic test_basic(input string nm, input int rdy_pct, input int spur_cyc);
    logic [7:0] e, g;
    exp_q.delete();
    push_exp(12'h010, 3, 8);
    n_run++;
    if (exp_q.size() != 21) begin
      n_fail++; $display("FAIL %s model_len: got %0d required 21", nm, exp_q.size());
    end
    @(posedge clk); #1;
    start_adr = 12'h010; word_cnt = 13'd3; start1 = 1'b1;
    run(1'b0, rdy_pct, spur_cyc, 2000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_run++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL %s byte: got none required %02h", nm, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL %s byte: got %02h required %02h", nm, g, e); end
      end
    end
    n_run++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL %s extra bytes: got %0d required 0", nm, got_q.size()); end
    n_run++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL %s done_cnt: got %0d required 1", nm, done_cnt); end
    n_run++;
    if (busy_after != 0) begin n_fail++; $display("FAIL %s busy_after_done: got %0d required 0", nm, busy_after); end
    n_run++;
    if (stall_err != 0) begin n_fail++; $display("FAIL %s tx_dat_stable: got %0d violations required 0", nm, stall_err); end
  endtask

  task automatic test_wpl2();
    logic [7:0] e, g;
    int n;
    for (int i = 0; i < 5; i++) mem[i] = 16'($urandom);
    exp_q.delete();
    push_exp(12'h000, 5, 2);
    @(posedge clk); #1;
    start_adr = 12'h000; word_cnt = 13'd5; start2 = 1'b1;
    run(1'b1, 100, -1, 2000);
    n_run++;
    if (got_q.size() != 31) begin n_fail++; $display("FAIL wpl2 length: got %0d required 31", got_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_run++;
      if (g !== e) begin n_fail++; $display("FAIL wpl2 byte %0d: got %02h required %02h", n, g, e); end
      n++;
    end
    n_run++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL wpl2 done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_wrap();
    logic [7:0] e, g;
    mem[12'hfff] = 16'h5a0f; mem[12'h000] = 16'hc3e1;
    exp_q.delete();
    push_exp(12'hfff, 2, 8);
    @(posedge clk); #1;
    start_adr = 12'hfff; word_cnt = 13'd2; start1 = 1'b1;
    run(1'b0, 100, -1, 2000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_run++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL wrap byte: got none required %02h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL wrap byte: got %02h required %02h", g, e); end
      end
    end
    n_run++;
    if (adr_q.size() != 2) begin
      n_fail++; $display("FAIL wrap mem_re_count: got %0d required 2", adr_q.size());
    end else begin
      n_run++;
      if (adr_q[0] !== 12'hfff || adr_q[1] !== 12'h000) begin
        n_fail++; $display("FAIL wrap mem_adr_seq: got %03h,%03h required fff,000", adr_q[0], adr_q[1]);
      end
    end
  endtask

  task automatic test_zero_cnt();
    int vld_seen;
    @(posedge clk); #1;
    start_adr = 12'h055; word_cnt = 13'd0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    n_run++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL zero done/busy: got %0b/%0b required 1/0", done1, busy1);
    end
    vld_seen = tx_vld1 ? 1 : 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (tx_vld1 || done1) vld_seen++;
    end
    n_run++;
    if (vld_seen != 0) begin n_fail++; $display("FAIL zero tx_vld_or_redone: got %0d cycles required 0", vld_seen); end
  endtask

  task automatic test_abort_rst();
    logic [7:0] e, g;
    int cnt;
    @(posedge clk); #1;
    start_adr = 12'h010; word_cnt = 13'd3; start1 = 1'b1; tx_rdy = 1'b1;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 8; c++) begin
      @(posedge clk); #1; start1 = 1'b0;
      @(negedge clk);
      if (tx_vld1 && tx_rdy) cnt++;
    end
    n_run++;
    if (cnt != 8) begin n_fail++; $display("FAIL abort reach_whex: got %0d bytes required 8", cnt); end
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    n_run++;
    if (tx_vld1 !== 1'b0 || done1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL abort outputs: got vld=%0b done=%0b busy=%0b required 0/1/0", tx_vld1, done1, busy1);
    end
    exp_q.delete();
    push_exp(12'h0ab, 1, 8);
    @(posedge clk); #1;
    start_adr = 12'h0ab; word_cnt = 13'd1; start1 = 1'b1;
    run(1'b0, 100, -1, 500);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_run++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL post_abort byte: got none required %02h", e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL post_abort byte: got %02h required %02h", g, e); end
      end
    end
    @(posedge clk); #1;
    start_adr = 12'h010; word_cnt = 13'd3; start1 = 1'b1;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; start1 = 1'b0; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_run++;
    if ({busy1, done1, mem_re1, tx_vld1, mem_adr1, tx_dat1} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid outputs: got b=%0b d=%0b re=%0b v=%0b adr=%03h dat=%02h, all required 0",
               busy1, done1, mem_re1, tx_vld1, mem_adr1, tx_dat1);
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 16'h9e37);
    mem[12'h010] = 16'h1234; mem[12'h011] = 16'habcd; mem[12'h012] = 16'h00ff;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic("basic", 100, -1);
    test_wpl2();
    test_basic("backpressure", 30, -1);
    test_wrap();
    test_zero_cnt();
    test_basic("start_while_busy", 100, 10);
    test_abort_rst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
